// File: rtl/conv_sched_if.sv
// Signal bundle between the convolution scheduler and its buffers, start-pointer unit and psum write buffer.
// The surrounding units form the master side; the scheduler itself is the slave side.
interface conv_sched_if #(
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PSUM_ADDR_WIDTH   = 6,
    parameter int SLOT_WIDTH        = 1
);
    logic                         start_i;
    logic                         if_empty_i;
    logic                         reading_empty_i;
    logic                         filter_cannot_read_i;
    logic                         sp_valid_i;
    logic [FILTER_ADDR_WIDTH-1:0] filter_waddr_i;
    logic                         stride_ended_i;
    logic                         ended_i;
    logic                         f_co_i;
    logic                         go_next_stride_i;
    logic                         go_next_filter_i;
    logic                         is_last_filter_i;
    logic                         psum_mode_i;
    logic                         psum_valid_i;
    logic                         can_read_psum_i;
    logic [1:0]                   wr_status_i;
    logic                         error_i;

    logic                         busy_o;
    logic                         global_rst_o;
    logic                         en_p_traverse_o;
    logic                         ren_o;
    logic                         ld_if_o;
    logic                         mult_en_o;
    logic                         i_en_o;
    logic                         ld_result_o;
    logic                         en_f_counter_o;
    logic                         rst_f_counter_o;
    logic                         next_start_o;
    logic                         next_stride_o;
    logic                         next_filter_o;
    logic                         rst_stride_o;
    logic                         first_time_o;
    logic                         rst_if_ctx_o;
    logic                         psum_ren_o;
    logic [PSUM_ADDR_WIDTH-1:0]   psum_raddr_o;
    logic [PSUM_ADDR_WIDTH-1:0]   psum_waddr_o;
    logic [SLOT_WIDTH-1:0]        filter_slot_o;
    logic                         done_o;
    logic                         err_flag_o;

    modport master (
        output start_i, if_empty_i, reading_empty_i, filter_cannot_read_i, sp_valid_i, filter_waddr_i,
               stride_ended_i, ended_i, f_co_i, go_next_stride_i, go_next_filter_i, is_last_filter_i,
               psum_mode_i, psum_valid_i, can_read_psum_i, wr_status_i, error_i,
        input  busy_o, global_rst_o, en_p_traverse_o, ren_o, ld_if_o, mult_en_o, i_en_o, ld_result_o,
               en_f_counter_o, rst_f_counter_o, next_start_o, next_stride_o, next_filter_o, rst_stride_o,
               first_time_o, rst_if_ctx_o, psum_ren_o, psum_raddr_o, psum_waddr_o, filter_slot_o,
               done_o, err_flag_o
    );

    modport slave (
        input  start_i, if_empty_i, reading_empty_i, filter_cannot_read_i, sp_valid_i, filter_waddr_i,
               stride_ended_i, ended_i, f_co_i, go_next_stride_i, go_next_filter_i, is_last_filter_i,
               psum_mode_i, psum_valid_i, can_read_psum_i, wr_status_i, error_i,
        output busy_o, global_rst_o, en_p_traverse_o, ren_o, ld_if_o, mult_en_o, i_en_o, ld_result_o,
               en_f_counter_o, rst_f_counter_o, next_start_o, next_stride_o, next_filter_o, rst_stride_o,
               first_time_o, rst_if_ctx_o, psum_ren_o, psum_raddr_o, psum_waddr_o, filter_slot_o,
               done_o, err_flag_o
    );
endinterface

// File: rtl/conv_sched_controller.sv
// Sequencing FSM of the convolution engine: pipeline fill, interleaved filter slots, psum address
// counters and the psum read/accumulate/write handshake with the write-buffer controller.
module conv_sched_controller #(
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PSUM_ADDR_WIDTH   = 6,
    parameter int PSUM_DEPTH        = 64,
    parameter int NUM_SLOTS         = 2,
    parameter int PIPE_DEPTH        = 2
) (
    input  logic        clk,
    input  logic        reset,
    conv_sched_if.slave bus
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int FILL_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [SLOT_W-1:0]          SLOT_LAST   = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0]          SLOT_ZERO   = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0]          SLOT_ONE    = SLOT_W'(1);
    localparam logic [FILL_W-1:0]          FILL_LAST   = FILL_W'(PIPE_DEPTH - 1);
    localparam logic [FILL_W-1:0]          FILL_ZERO   = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0]          FILL_ONE    = FILL_W'(1);
    localparam logic [PSUM_ADDR_WIDTH-1:0] PSUM_LAST   = PSUM_ADDR_WIDTH'(PSUM_DEPTH - 1);
    localparam logic [PSUM_ADDR_WIDTH-1:0] PSUM_ZERO   = {PSUM_ADDR_WIDTH{1'b0}};
    localparam logic [PSUM_ADDR_WIDTH-1:0] PSUM_ONE    = PSUM_ADDR_WIDTH'(1);
    localparam logic                       SINGLE_SLOT = (NUM_SLOTS == 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ARM       = 4'd1,
        S_START     = 4'd2,
        S_FIND_SP   = 4'd3,
        S_FILL      = 4'd4,
        S_RUN       = 4'd5,
        S_NEXT_IF   = 4'd6,
        S_UPDATE_SP = 4'd7,
        S_NEXT_PSUM = 4'd8,
        S_READ_REQ  = 4'd9,
        S_WRITE_REQ = 4'd10,
        S_WAIT_WR   = 4'd11,
        S_ADD_NEXT  = 4'd12,
        S_DONE      = 4'd13,
        S_ERR       = 4'd14
    } state_e;

    state_e                     state_q, state_d;
    logic [PSUM_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [PSUM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [SLOT_W-1:0]          slot_q, slot_d;
    logic [FILL_W-1:0]          fill_q, fill_d;

    logic                       freeze_s;
    logic                       run_s;
    logic                       slot_last_s;
    logic [SLOT_W-1:0]          slot_inc_s;
    logic [PSUM_ADDR_WIDTH-1:0] raddr_inc_s;

    // A last-filter switch also freezes the datapath so no stale filter data is consumed.
    assign freeze_s    = bus.reading_empty_i | bus.filter_cannot_read_i | !bus.sp_valid_i
                       | (bus.is_last_filter_i & bus.go_next_filter_i);
    assign run_s       = !freeze_s & !bus.f_co_i;
    assign slot_last_s = (slot_q == SLOT_LAST);
    assign slot_inc_s  = slot_last_s ? SLOT_ZERO : (slot_q + SLOT_ONE);
    assign raddr_inc_s = (raddr_q == PSUM_LAST) ? PSUM_ZERO : (raddr_q + PSUM_ONE);

    assign bus.psum_raddr_o  = raddr_q;
    assign bus.psum_waddr_o  = waddr_q;
    assign bus.filter_slot_o = slot_q;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            raddr_q <= PSUM_ZERO;
            waddr_q <= PSUM_ZERO;
            slot_q  <= SLOT_ZERO;
            fill_q  <= FILL_ZERO;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            slot_q  <= slot_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state, counter updates and state-decoded outputs.
    always_comb begin
        state_d             = state_q;
        raddr_d             = raddr_q;
        waddr_d             = waddr_q;
        slot_d              = slot_q;
        fill_d              = fill_q;
        bus.busy_o          = (state_q != S_IDLE);
        bus.global_rst_o    = 1'b0;
        bus.en_p_traverse_o = 1'b0;
        bus.ren_o           = 1'b0;
        bus.ld_if_o         = 1'b0;
        bus.mult_en_o       = 1'b0;
        bus.i_en_o          = 1'b0;
        bus.ld_result_o     = 1'b0;
        bus.en_f_counter_o  = 1'b0;
        bus.rst_f_counter_o = 1'b0;
        bus.next_start_o    = 1'b0;
        bus.next_stride_o   = 1'b0;
        bus.next_filter_o   = 1'b0;
        bus.rst_stride_o    = 1'b0;
        bus.first_time_o    = 1'b0;
        bus.rst_if_ctx_o    = 1'b0;
        bus.psum_ren_o      = 1'b0;
        bus.done_o          = 1'b0;
        bus.err_flag_o      = 1'b0;

        case (state_q)
            S_IDLE: state_d = bus.start_i ? S_ARM : S_IDLE;
            S_ARM: begin
                bus.global_rst_o = 1'b1;
                raddr_d          = PSUM_ZERO;
                waddr_d          = PSUM_ZERO;
                slot_d           = SLOT_ZERO;
                fill_d           = FILL_ZERO;
                state_d          = bus.start_i ? S_ARM : S_START;
            end
            S_START: begin
                if (!bus.if_empty_i && (bus.filter_waddr_i != {FILTER_ADDR_WIDTH{1'b0}})) begin
                    state_d = S_FIND_SP;
                end else begin
                    state_d = S_START;
                end
            end
            S_FIND_SP: begin
                bus.en_p_traverse_o = !bus.sp_valid_i;
                if (bus.sp_valid_i) begin
                    fill_d  = FILL_ZERO;
                    state_d = S_FILL;
                end else begin
                    state_d = S_FIND_SP;
                end
            end
            S_FILL: begin
                bus.ren_o     = !freeze_s;
                bus.ld_if_o   = !freeze_s;
                bus.i_en_o    = !freeze_s;
                bus.mult_en_o = !freeze_s && (fill_q != FILL_ZERO);
                fill_d        = freeze_s ? fill_q : (fill_q + FILL_ONE);
                state_d       = (!freeze_s && (fill_q == FILL_LAST)) ? S_RUN : S_FILL;
            end
            S_RUN: begin
                bus.ld_if_o        = run_s;
                bus.i_en_o         = run_s;
                bus.ld_result_o    = run_s;
                bus.mult_en_o      = run_s;
                bus.ren_o          = run_s;
                bus.en_f_counter_o = run_s;
                slot_d             = (!freeze_s && bus.go_next_stride_i) ? slot_inc_s : slot_q;
                // Strides only advance once every interleaved slot has consumed the current one.
                bus.next_stride_o  = run_s & !bus.stride_ended_i & !bus.ended_i
                                   & bus.go_next_stride_i & slot_last_s;
                bus.next_filter_o  = !freeze_s & bus.go_next_filter_i & (SINGLE_SLOT | !slot_last_s);
                bus.rst_stride_o   = bus.next_filter_o;
                raddr_d            = bus.psum_mode_i ? PSUM_ZERO : raddr_q;
                if (bus.psum_mode_i) begin
                    state_d = S_READ_REQ;
                end else if (bus.is_last_filter_i && bus.go_next_filter_i) begin
                    state_d = S_NEXT_IF;
                end else if (bus.f_co_i && !freeze_s) begin
                    state_d = S_NEXT_PSUM;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_NEXT_IF: begin
                bus.rst_if_ctx_o = 1'b1;
                bus.rst_stride_o = 1'b1;
                slot_d           = SLOT_ZERO;
                state_d          = S_UPDATE_SP;
            end
            S_UPDATE_SP: begin
                bus.next_start_o = 1'b1;
                state_d          = S_RUN;
            end
            S_NEXT_PSUM: begin
                bus.rst_f_counter_o = 1'b1;
                bus.first_time_o    = 1'b1;
                bus.rst_if_ctx_o    = !bus.is_last_filter_i;
                raddr_d             = bus.psum_mode_i ? raddr_q : raddr_inc_s;
                // The last psum entry finishes the job instead of wrapping onto entry 0.
                if (waddr_q == PSUM_LAST) begin
                    state_d = S_DONE;
                end else begin
                    waddr_d = waddr_q + PSUM_ONE;
                    state_d = bus.psum_mode_i ? S_READ_REQ : S_RUN;
                end
            end
            S_READ_REQ: begin
                bus.psum_ren_o = bus.can_read_psum_i;
                state_d        = bus.psum_valid_i ? S_WRITE_REQ : S_READ_REQ;
            end
            S_WRITE_REQ: begin
                bus.rst_f_counter_o = 1'b1;
                bus.psum_ren_o      = 1'b1;
                state_d             = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                bus.psum_ren_o = 1'b1;
                case (bus.wr_status_i)
                    2'b00:   state_d = S_WAIT_WR;
                    2'b10:   state_d = S_ADD_NEXT;
                    2'b11:   state_d = S_DONE;
                    default: state_d = S_ERR;
                endcase
            end
            S_ADD_NEXT: begin
                raddr_d = raddr_inc_s;
                state_d = S_READ_REQ;
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_d    = bus.start_i ? S_ARM : S_DONE;
            end
            S_ERR: begin
                bus.err_flag_o = 1'b1;
                state_d        = S_ERR;
            end
            default: state_d = S_ERR;
        endcase

        if (bus.error_i) begin
            state_d = S_ERR;
        end else begin
            state_d = state_d;
        end
    end
endmodule

// File: tb/tb_conv_sched_controller.sv
// Randomized scoreboard bench for conv_sched_controller: output pulse events are predicted from the
// sequencing rules and matched by an independent monitor, plus per-cycle enable checks.
module tb_conv_sched_controller;
    localparam int FAW = 8, PAW = 6, PD = 64, NS = 3, PIPE = 3, SW = 2;
    localparam int K_GRST = 0, K_STRIDE = 1, K_NFILT = 2, K_NSTART = 3;
    localparam int K_PSUM = 4, K_WREQ = 5, K_DONE = 6, K_ERR = 7;

    logic clk = 1'b0;
    logic reset;

    conv_sched_if #(.FILTER_ADDR_WIDTH(FAW), .PSUM_ADDR_WIDTH(PAW), .SLOT_WIDTH(SW)) bus ();

    conv_sched_controller #(
        .FILTER_ADDR_WIDTH(FAW), .PSUM_ADDR_WIDTH(PAW), .PSUM_DEPTH(PD),
        .NUM_SLOTS(NS), .PIPE_DEPTH(PIPE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int data; } ev_t;
    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  m_slot, m_waddr, m_raddr;
    logic done_prev = 1'b0, err_prev = 1'b0;

    wire [32:0] all_out = {bus.busy_o, bus.global_rst_o, bus.en_p_traverse_o, bus.ren_o, bus.ld_if_o,
                           bus.mult_en_o, bus.i_en_o, bus.ld_result_o, bus.en_f_counter_o,
                           bus.rst_f_counter_o, bus.next_start_o, bus.next_stride_o, bus.next_filter_o,
                           bus.rst_stride_o, bus.first_time_o, bus.rst_if_ctx_o, bus.psum_ren_o,
                           bus.psum_raddr_o, bus.psum_waddr_o, bus.filter_slot_o, bus.done_o,
                           bus.err_flag_o};

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_ev(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start_i = 1'b0;           bus.if_empty_i = 1'b1;      bus.reading_empty_i = 1'b0;
        bus.filter_cannot_read_i = 1'b0; bus.sp_valid_i = 1'b1;   bus.filter_waddr_i = 8'd0;
        bus.stride_ended_i = 1'b0;    bus.ended_i = 1'b0;         bus.f_co_i = 1'b0;
        bus.go_next_stride_i = 1'b0;  bus.go_next_filter_i = 1'b0; bus.is_last_filter_i = 1'b0;
        bus.psum_mode_i = 1'b0;       bus.psum_valid_i = 1'b0;    bus.can_read_psum_i = 1'b0;
        bus.wr_status_i = 2'b00;      bus.error_i = 1'b0;
    endtask

    task automatic set_freeze(input int src, input bit on);
        case (src)
            0:       bus.reading_empty_i = on;
            1:       bus.filter_cannot_read_i = on;
            default: bus.sp_valid_i = !on;
        endcase
    endtask

    // Start a job from IDLE/DONE and walk it into RUN; counters are expected back at zero.
    task automatic bring_up();
        int hold, src;
        bus.start_i = 1'b1;
        expect_ev(K_GRST, 0);
        cyc();
        bus.start_i = 1'b0;
        smp(); check("arm_busy", bus.busy_o, 1);
        cyc();
        bus.sp_valid_i = 1'b0;
        bus.filter_waddr_i = 8'd5;
        smp(); check("start_waddr_clr", bus.psum_waddr_o, 0); check("start_slot_clr", bus.filter_slot_o, 0);
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            bus.if_empty_i = 1'b1;
            smp(); check("start_gate_no_trav", bus.en_p_traverse_o, 0);
            cyc();
        end
        bus.if_empty_i = 1'b0;
        cyc();
        for (int h = 0; h < 2; h++) begin
            smp(); check("find_sp_trav", bus.en_p_traverse_o, 1); check("find_sp_ren", bus.ren_o, 0);
            cyc();
        end
        bus.sp_valid_i = 1'b1;
        smp(); check("find_sp_found", bus.en_p_traverse_o, 0);
        cyc();
        for (int i = 0; i < PIPE; i++) begin
            if (i == 1 || $urandom_range(0, 2) == 0) begin
                src = $urandom_range(0, 2);
                set_freeze(src, 1'b1);
                for (int c = 0; c < 4; c++) begin
                    smp(); check("fill_frz_ren", bus.ren_o, 0); check("fill_frz_mult", bus.mult_en_o, 0);
                    check("fill_frz_ldif", bus.ld_if_o, 0);
                    cyc();
                end
                set_freeze(src, 1'b0);
            end
            smp(); check("fill_ren", bus.ren_o, 1); check("fill_i_en", bus.i_en_o, 1);
            check("fill_mult", bus.mult_en_o, int'(i > 0)); check("fill_ldres", bus.ld_result_o, 0);
            cyc();
        end
        smp(); check("run_ldres", bus.ld_result_o, 1); check("run_fcnt", bus.en_f_counter_o, 1);
        cyc();
    endtask

    // One filter-count completion in RUN; returns 1 when it closed the last psum entry.
    task automatic do_fco(output bit finished);
        if ($urandom_range(0, 4) == 0) begin
            bus.f_co_i = 1'b1; bus.reading_empty_i = 1'b1;
            smp(); check("fco_frozen_ren", bus.ren_o, 0);
            cyc();
            bus.reading_empty_i = 1'b0;
        end
        bus.f_co_i = 1'b1;
        expect_ev(K_PSUM, m_raddr * 256 + m_waddr);
        finished = (m_waddr == PD - 1);
        if (finished) expect_ev(K_DONE, PD - 1);
        smp(); check("fco_run_ren", bus.ren_o, 0);
        cyc();
        bus.f_co_i = 1'b0;
        smp(); check("next_psum_ctx", bus.rst_if_ctx_o, 1);
        cyc();
        if (!finished) begin
            m_waddr++;
            m_raddr = (m_raddr + 1) % PD;
        end
    endtask

    // Drive RUN into the psum handshake and stop in WAIT_WR.
    task automatic to_wait_wr();
        bus.psum_mode_i = 1'b1;
        cyc();
        bus.psum_valid_i = 1'b1; bus.can_read_psum_i = 1'b1;
        expect_ev(K_WREQ, 0);
        cyc();
        bus.psum_valid_i = 1'b0;
        cyc();
    endtask

    task automatic reset_and_idle();
        idle_inputs();
        reset = 1'b1;
        #1 check("reset_outs_zero", int'(all_out == 33'd0), 1);
        cyc();
        reset = 1'b0;
        smp(); check("idle_outs_zero", int'(all_out == 33'd0), 1);
        cyc();
    endtask

    always @(posedge clk) begin
        done_prev <= bus.done_o;
        err_prev  <= bus.err_flag_o;
    end

    // Monitor: every output pulse event must match the head of the expectation queue.
    always @(negedge clk) begin
        int kind, data;
        ev_t e;
        kind = -1;
        data = 0;
        if (bus.global_rst_o) kind = K_GRST;
        else if (bus.next_stride_o) begin kind = K_STRIDE; data = int'(bus.filter_slot_o); end
        else if (bus.next_filter_o) begin kind = K_NFILT; data = int'(bus.filter_slot_o); end
        else if (bus.next_start_o) begin kind = K_NSTART; data = int'(bus.filter_slot_o); end
        else if (bus.rst_f_counter_o && bus.first_time_o) begin
            kind = K_PSUM; data = int'(bus.psum_raddr_o) * 256 + int'(bus.psum_waddr_o);
        end
        else if (bus.rst_f_counter_o && bus.psum_ren_o) begin kind = K_WREQ; data = int'(bus.psum_raddr_o); end
        else if (bus.done_o && !done_prev) begin kind = K_DONE; data = int'(bus.psum_waddr_o); end
        else if (bus.err_flag_o && !err_prev) kind = K_ERR;
        if (kind >= 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_data", data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        int  op, loops, w;
        bit  se, fin;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        smp(); check("reset_outs_zero", int'(all_out == 33'd0), 1);
        cyc();
        reset = 1'b0;
        smp(); check("idle_outs_zero", int'(all_out == 33'd0), 1);
        cyc();

        bring_up();
        m_slot = 0;
        bus.reading_empty_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.go_next_stride_i = (c == 1);
            smp(); check("run_frz_ren", bus.ren_o, 0); check("run_frz_ldres", bus.ld_result_o, 0);
            cyc();
        end
        bus.reading_empty_i = 1'b0; bus.go_next_stride_i = 1'b0;
        smp(); check("run_resume_ren", bus.ren_o, 1); check("slot_frozen", bus.filter_slot_o, 0);
        cyc();

        for (int i = 0; i < 24; i++) begin
            op = (i < 3) ? 0 : $urandom_range(0, 2);
            if (op == 0) begin
                se = (i >= 3) && ($urandom_range(0, 3) == 0);
                bus.stride_ended_i = se; bus.go_next_stride_i = 1'b1;
                if (m_slot == NS - 1 && !se) expect_ev(K_STRIDE, NS - 1);
                cyc();
                bus.stride_ended_i = 1'b0; bus.go_next_stride_i = 1'b0;
                m_slot = (m_slot + 1) % NS;
                smp(); check("slot_after_stride", bus.filter_slot_o, m_slot);
                cyc();
            end else if (op == 1) begin
                bus.go_next_filter_i = 1'b1;
                if (m_slot != NS - 1) expect_ev(K_NFILT, m_slot);
                cyc();
                bus.go_next_filter_i = 1'b0;
            end else begin
                repeat ($urandom_range(1, 3)) cyc();
            end
        end

        bus.is_last_filter_i = 1'b1; bus.go_next_filter_i = 1'b1;
        expect_ev(K_NSTART, 0);
        smp(); check("last_filter_ren", bus.ren_o, 0);
        cyc();
        bus.is_last_filter_i = 1'b0; bus.go_next_filter_i = 1'b0;
        smp(); check("next_if_ctx", bus.rst_if_ctx_o, 1); check("next_if_rst_stride", bus.rst_stride_o, 1);
        cyc();
        cyc();
        m_slot = 0;
        smp(); check("slot_after_if", bus.filter_slot_o, 0); check("run_after_if", bus.ren_o, 1);
        cyc();

        m_waddr = 0; m_raddr = 0; fin = 1'b0;
        while (!fin) do_fco(fin);
        for (int c = 0; c < 3; c++) begin
            smp(); check("done_held", bus.done_o, 1); check("done_waddr", bus.psum_waddr_o, PD - 1);
            check("done_busy", bus.busy_o, 1);
            cyc();
        end

        bring_up();
        m_waddr = 0; m_raddr = 0;
        repeat (2) do_fco(fin);
        bus.psum_mode_i = 1'b1;
        cyc();
        m_raddr = 0;
        loops = $urandom_range(2, 4);
        for (int k = 0; k <= loops; k++) begin
            smp(); check("rd_raddr", bus.psum_raddr_o, m_raddr);
            w = $urandom_range(0, 2);
            for (int c = 0; c < w; c++) begin
                bus.can_read_psum_i = $urandom_range(0, 1);
                smp(); check("rd_psum_ren", bus.psum_ren_o, int'(bus.can_read_psum_i));
                cyc();
            end
            bus.psum_valid_i = 1'b1; bus.can_read_psum_i = 1'b1;
            expect_ev(K_WREQ, m_raddr);
            cyc();
            bus.psum_valid_i = 1'b0;
            cyc();
            for (int c = 0; c < $urandom_range(0, 2); c++) begin
                smp(); check("wait_wr_ren", bus.psum_ren_o, 1);
                cyc();
            end
            if (k < loops) begin
                bus.wr_status_i = 2'b10;
                cyc();
                bus.wr_status_i = 2'b00;
                cyc();
                m_raddr = (m_raddr + 1) % PD;
            end else begin
                bus.wr_status_i = 2'b11;
                expect_ev(K_DONE, m_waddr);
                cyc();
                bus.wr_status_i = 2'b00;
                smp(); check("psum_done", bus.done_o, 1);
                cyc();
            end
        end
        bus.psum_mode_i = 1'b0;

        bring_up();
        to_wait_wr();
        bus.error_i = 1'b1;
        expect_ev(K_ERR, 0);
        cyc();
        bus.error_i = 1'b0; bus.start_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            smp(); check("err_sticky", bus.err_flag_o, 1); check("err_ren", bus.ren_o, 0);
            check("err_psum_ren", bus.psum_ren_o, 0); check("err_busy", bus.busy_o, 1);
            cyc();
        end
        reset_and_idle();

        bring_up();
        to_wait_wr();
        bus.wr_status_i = 2'b01;
        expect_ev(K_ERR, 0);
        cyc();
        bus.wr_status_i = 2'b00;
        for (int c = 0; c < 2; c++) begin
            smp(); check("wrstat_err_sticky", bus.err_flag_o, 1);
            cyc();
        end
        reset_and_idle();

        bring_up();
        bus.f_co_i = 1'b1;
        #2 reset = 1'b1;
        #1 check("reset_midrun_zero", int'(all_out == 33'd0), 1);
        for (int c = 0; c < 2; c++) begin
            smp(); check("reset_hold_zero", int'(all_out == 33'd0), 1);
            cyc();
        end
        idle_inputs();
        reset = 1'b0;
        smp(); check("post_reset_idle", int'(all_out == 33'd0), 1);
        cyc();

        repeat (2) cyc();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
